// File: rtl/hex_reader_if.sv
// Output stream of the hex reader: one decoded nibble per
// valid/out_ready transfer, tagged with its digit index and error flag.
interface hex_reader_if;
    logic [3:0] data;
    logic       valid;
    logic [2:0] idx;
    logic       err;
    logic       out_ready;

    modport master (
        output data, valid, idx, err,
        input  out_ready
    );

    modport slave (
        input  data, valid, idx, err,
        output out_ready
    );
endinterface

// File: rtl/hex_reader.sv
// Captures six seven-segment patterns on start and streams them
// out as decoded nibbles, counting illegal glyphs per frame.
module hex_reader #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [6:0]   hex0,
    input  logic [6:0]   hex1,
    input  logic [6:0]   hex2,
    input  logic [6:0]   hex3,
    input  logic [6:0]   hex4,
    input  logic [6:0]   hex5,
    hex_reader_if.master bus,
    output logic [2:0]   err_cnt,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t     state;
    logic [6:0] snap [6];

    // Returns {err, data}; patterns are normalised to active-low first.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [6:0] p;
        p = SEG_ACTIVE_LOW ? seg : ~seg;
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h08:   decode = 5'h0A;
            7'h03:   decode = 5'h0B;
            7'h46:   decode = 5'h0C;
            7'h21:   decode = 5'h0D;
            7'h06:   decode = 5'h0E;
            7'h0E:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // Snapshot slot selection; out-of-range indices never occur.
    function automatic logic [6:0] pick(input logic [2:0] k);
        case (k)
            3'd0:    pick = snap[0];
            3'd1:    pick = snap[1];
            3'd2:    pick = snap[2];
            3'd3:    pick = snap[3];
            3'd4:    pick = snap[4];
            default: pick = snap[5];
        endcase
    endfunction

    // Frame FSM with registered stream, status and snapshot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bus.data  <= '0;
            bus.valid <= 1'b0;
            bus.idx   <= '0;
            bus.err   <= 1'b0;
            err_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 6; i++) snap[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap[0] <= hex0;
                        snap[1] <= hex1;
                        snap[2] <= hex2;
                        snap[3] <= hex3;
                        snap[4] <= hex4;
                        snap[5] <= hex5;
                        {bus.err, bus.data} <= decode(hex0);
                        bus.idx   <= 3'd0;
                        bus.valid <= 1'b1;
                        busy      <= 1'b1;
                        err_cnt   <= 3'd0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bus.valid && bus.out_ready) begin
                        if (bus.err && err_cnt != 3'd7)
                            err_cnt <= err_cnt + 3'd1;
                        if (bus.idx == 3'd5) begin
                            bus.valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus.idx <= bus.idx + 3'd1;
                            {bus.err, bus.data} <= decode(pick(bus.idx + 3'd1));
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
